// File: rtl/dcache_arb.sv
`default_nettype none
// ============================================================================
// dcache_arb : round-robin arbiter sharing the dcache master port between
//              MASTERCOUNT requesters; optional bus lock via DCACHE_ARB_CYCLOCK_EN
// Revision   : 1.0
// ============================================================================
module dcache_arb #(
  parameter int  ARCHBITSZ   = 16,
  parameter int  MASTERCOUNT = 2,
  localparam int ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  localparam int SELBITSZ    = ARCHBITSZ/8,
  localparam int GRANTBITSZ  = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [MASTERCOUNT-1:0]          m_wb_cyc_i,
  input  logic [MASTERCOUNT-1:0]          m_wb_stb_i,
  input  logic [MASTERCOUNT-1:0]          m_wb_we_i,
  input  logic [MASTERCOUNT-1:0]          m_conly_i,
  input  logic [MASTERCOUNT-1:0]          m_cmiss_i,
  input  logic [MASTERCOUNT*ADDRBITSZ-1:0] m_wb_addr_i,
  input  logic [MASTERCOUNT*SELBITSZ-1:0]  m_wb_sel_i,
  input  logic [MASTERCOUNT*ARCHBITSZ-1:0] m_wb_dat_i,
  output logic [MASTERCOUNT-1:0]          m_wb_bsy_o,
  output logic [MASTERCOUNT-1:0]          m_wb_ack_o,
  output logic [ARCHBITSZ-1:0]            m_wb_dat_o,
  output logic                            s_wb_cyc_o,
  output logic                            s_wb_stb_o,
  output logic                            s_wb_we_o,
  output logic [ADDRBITSZ-1:0]            s_wb_addr_o,
  output logic [SELBITSZ-1:0]             s_wb_sel_o,
  output logic [ARCHBITSZ-1:0]            s_wb_dat_o,
  output logic                            s_conly_o,
  output logic                            s_cmiss_o,
  input  logic                            s_wb_bsy_i,
  input  logic                            s_wb_ack_i,
  input  logic [ARCHBITSZ-1:0]            s_wb_dat_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GRANTBITSZ-1:0]   gnt_q, gnt_d;
  logic [GRANTBITSZ-1:0]   last_q, last_d;
  logic [MASTERCOUNT-1:0]  req_w;
  logic [GRANTBITSZ-1:0]   pick_w;
  logic [GRANTBITSZ-1:0]   idx_w;
  logic                    pick_vld_w;
  logic                    cyc_g_w;
  logic                    stb_g_w;

  assign req_w      = m_wb_cyc_i & m_wb_stb_i;
  assign m_wb_dat_o = s_wb_dat_i;

  // Scan from the farthest candidate to the nearest so the one closest
  // after last_q is the final (winning) assignment.
  always_comb begin
    pick_w     = '0;
    pick_vld_w = 1'b0;
    idx_w      = '0;
    for (int k = MASTERCOUNT; k >= 1; k--) begin
      idx_w = GRANTBITSZ'((int'(last_q) + k) % MASTERCOUNT);
      if (req_w[idx_w]) begin
        pick_w     = idx_w;
        pick_vld_w = 1'b1;
      end
    end
  end

  always_comb begin
    cyc_g_w     = m_wb_cyc_i[0];
    stb_g_w     = m_wb_stb_i[0];
    s_wb_we_o   = m_wb_we_i[0];
    s_conly_o   = m_conly_i[0];
    s_cmiss_o   = m_cmiss_i[0];
    s_wb_addr_o = m_wb_addr_i[ADDRBITSZ-1:0];
    s_wb_sel_o  = m_wb_sel_i[SELBITSZ-1:0];
    s_wb_dat_o  = m_wb_dat_i[ARCHBITSZ-1:0];
    for (int i = 1; i < MASTERCOUNT; i++) begin
      if (gnt_q == GRANTBITSZ'(i)) begin
        cyc_g_w     = m_wb_cyc_i[i];
        stb_g_w     = m_wb_stb_i[i];
        s_wb_we_o   = m_wb_we_i[i];
        s_conly_o   = m_conly_i[i];
        s_cmiss_o   = m_cmiss_i[i];
        s_wb_addr_o = m_wb_addr_i[i*ADDRBITSZ +: ADDRBITSZ];
        s_wb_sel_o  = m_wb_sel_i[i*SELBITSZ +: SELBITSZ];
        s_wb_dat_o  = m_wb_dat_i[i*ARCHBITSZ +: ARCHBITSZ];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    m_wb_bsy_o = '1;
    m_wb_ack_o = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld_w) begin
          gnt_d   = pick_w;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_wb_cyc_o = cyc_g_w;
        s_wb_stb_o = stb_g_w;
        if (!s_wb_bsy_i) m_wb_bsy_o[gnt_q] = 1'b0;
        if (!cyc_g_w) begin
          state_d = IDLE;
        end else if (stb_g_w && !s_wb_bsy_i) begin
          state_d = WAIT;
          last_d  = gnt_q;
        end
      end
      WAIT: begin
        // The cache cannot abort, so cyc is held regardless of the requester.
        s_wb_cyc_o = 1'b1;
        if (s_wb_ack_i) begin
          m_wb_ack_o[gnt_q] = 1'b1;
`ifdef DCACHE_ARB_CYCLOCK_EN
          state_d = cyc_g_w ? ISSUE : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GRANTBITSZ'(MASTERCOUNT - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_arb.sv
`default_nettype none
// ============================================================================
// tb_dcache_arb : self-checking bench for dcache_arb (2 requesters, 16-bit)
// Revision      : 1.0
// ============================================================================
module tb_dcache_arb;

  typedef struct {
    int          req;
    logic [14:0] addr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wdat;
    logic        co;
    logic        cm;
    logic [15:0] rdat;
  } xfer_t;

  typedef struct {
    int          req;
    logic [1:0]  ack;
    logic [15:0] dat;
  } ack_t;

  logic        clk;
  logic        rst_i;
  logic [1:0]  m_cyc, m_stb, m_we, m_co, m_cm;
  logic [29:0] m_addr;
  logic [3:0]  m_sel;
  logic [31:0] m_wdat;
  logic [1:0]  m_wb_bsy_o, m_wb_ack_o;
  logic [15:0] m_wb_dat_o;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_conly_o, s_cmiss_o;
  logic [14:0] s_wb_addr_o;
  logic [1:0]  s_wb_sel_o;
  logic [15:0] s_wb_dat_o;
  logic        s_wb_bsy_i, s_wb_ack_i;
  logic [15:0] s_wb_dat_i;

  dcache_arb #(.ARCHBITSZ(16), .MASTERCOUNT(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
    .m_conly_i(m_co), .m_cmiss_i(m_cm),
    .m_wb_addr_i(m_addr), .m_wb_sel_i(m_sel), .m_wb_dat_i(m_wdat),
    .m_wb_bsy_o(m_wb_bsy_o), .m_wb_ack_o(m_wb_ack_o), .m_wb_dat_o(m_wb_dat_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_addr_o(s_wb_addr_o), .s_wb_sel_o(s_wb_sel_o), .s_wb_dat_o(s_wb_dat_o),
    .s_conly_o(s_conly_o), .s_cmiss_o(s_cmiss_o),
    .s_wb_bsy_i(s_wb_bsy_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_dat_i(s_wb_dat_i)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  xfer_t       mq [2][$];
  xfer_t       exp_q[$];
  ack_t        ack_q[$];
  logic [1:0]  cyc_hold;
  int          ack_cnt;
  int          ack_lat;
  logic [15:0] ack_dat;
  xfer_t       vec [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic xfer_t mk(int r, logic [14:0] a, logic w, logic [1:0] s,
                               logic [15:0] wd, logic co, logic cm, logic [15:0] rd);
    xfer_t x;
    x.req = r; x.addr = a; x.we = w; x.sel = s; x.wdat = wd;
    x.co = co; x.cm = cm; x.rdat = rd;
    return x;
  endfunction

  task automatic drive_masters();
    for (int r = 0; r < 2; r++) begin
      m_cyc[r] = cyc_hold[r];
      if (cyc_hold[r] && mq[r].size() > 0) begin
        m_stb[r]             = 1'b1;
        m_we[r]              = mq[r][0].we;
        m_co[r]              = mq[r][0].co;
        m_cm[r]              = mq[r][0].cm;
        m_addr[r*15 +: 15]   = mq[r][0].addr;
        m_sel[r*2 +: 2]      = mq[r][0].sel;
        m_wdat[r*16 +: 16]   = mq[r][0].wdat;
      end else begin
        m_stb[r] = 1'b0;
      end
    end
  endtask

  task automatic drive_now();
    drive_masters();
    #1;
  endtask

  // One clock: scoreboard at the falling edge, then slave and masters react
  // just after the rising edge.
  task automatic tick();
    xfer_t e;
    ack_t  a;
    @(negedge clk);
    if (s_wb_cyc_o && s_wb_stb_o && !s_wb_bsy_i) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", {63'h0, s_wb_stb_o}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer", {s_wb_addr_o, s_wb_we_o, s_wb_sel_o, s_wb_dat_o, s_conly_o, s_cmiss_o},
                    {e.addr, e.we, e.sel, e.wdat, e.co, e.cm});
        if (mq[e.req].size() > 0) void'(mq[e.req].pop_front());
        ack_cnt = ack_lat;
        ack_dat = e.rdat;
        a.req = e.req; a.ack = 2'b01 << e.req; a.dat = e.rdat;
        ack_q.push_back(a);
      end
    end
    if (s_wb_ack_i || m_wb_ack_o != 2'b00) begin
      if (s_wb_ack_i && ack_q.size() > 0) begin
        a = ack_q.pop_front();
        chk("ack_vec", m_wb_ack_o, a.ack);
        chk("ack_dat", m_wb_dat_o, a.dat);
        if (mq[a.req].size() == 0) cyc_hold[a.req] = 1'b0;
      end else begin
        chk("ack_stray", m_wb_ack_o, 2'b00);
      end
    end
    @(posedge clk);
    #1;
    s_wb_ack_i = 1'b0;
    if (ack_cnt == 0) begin
      s_wb_ack_i = 1'b1;
      s_wb_dat_i = ack_dat;
      ack_cnt    = -1;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
    end
    drive_masters();
    #1;
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || ack_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, exp_q.size() + ack_q.size(), 0);
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic reset_model();
    exp_q.delete(); ack_q.delete(); mq[0].delete(); mq[1].delete();
    cyc_hold = 2'b00; ack_cnt = -1; ack_lat = 0;
    s_wb_ack_i = 1'b0; s_wb_bsy_i = 1'b0;
    drive_masters();
  endtask

  task automatic reset_pulse();
    rst_i = 1'b0;
    #1;
    reset_model();
    rst_i = 1'b1;
    #1;
  endtask

  task automatic issue(input xfer_t x);
    mq[x.req].push_back(x);
    exp_q.push_back(x);
    cyc_hold[x.req] = 1'b1;
  endtask

  initial begin
    int acks;
    int n;
    m_cyc = '0; m_stb = '0; m_we = '0; m_co = '0; m_cm = '0;
    m_addr = '0; m_sel = '0; m_wdat = '0;
    rst_i = 1'b0;
    s_wb_dat_i = 16'h1234;
    reset_model();
    #3;
    chk("rst_cyc", s_wb_cyc_o, 1'b0);
    chk("rst_stb", s_wb_stb_o, 1'b0);
    chk("rst_ack", m_wb_ack_o, 2'b00);
    chk("rst_bsy", m_wb_bsy_o, 2'b11);
    chk("rst_dat", m_wb_dat_o, 16'h1234);
    s_wb_ack_i = 1'b1;
    #1;
    chk("rst_stray_ack", m_wb_ack_o, 2'b00);
    s_wb_ack_i = 1'b0;
    @(posedge clk);
    #2;
    rst_i = 1'b1;

    // Single requester: requester 1 reads 0x12, cache returns 0xBEEF.
    issue(mk(1, 15'h0012, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hBEEF));
    drive_now();
    chk("single_idle_stb", s_wb_stb_o, 1'b0);
    tick();
    chk("single_addr", s_wb_addr_o, 15'h0012);
    chk("single_stb", s_wb_stb_o, 1'b1);
    chk("single_bsy_issue", m_wb_bsy_o, 2'b01);
    acks = 0;
    n = 0;
    while ((exp_q.size() > 0 || ack_q.size() > 0) && n < 20) begin
      tick();
      n++;
      if (m_wb_ack_o == 2'b10) acks++;
      chk("single_bsy0", m_wb_bsy_o[0], 1'b1);
    end
    tick();
    chk("single_ack_after", m_wb_ack_o, 2'b00);
    chk("single_ack_once", acks, 1);

    // Table of isolated transactions across both requesters.
    vec[0] = mk(0, 15'h0100, 1'b1, 2'b01, 16'hA5A5, 1'b0, 1'b0, 16'h0001);
    vec[1] = mk(1, 15'h7FFF, 1'b0, 2'b10, 16'h0000, 1'b1, 1'b0, 16'hFFFF);
    vec[2] = mk(0, 15'h0000, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h5A5A);
    vec[3] = mk(1, 15'h2AAA, 1'b1, 2'b11, 16'hC3C3, 1'b1, 1'b1, 16'h0000);
    vec[4] = mk(1, 15'h1555, 1'b1, 2'b01, 16'h0F0F, 1'b0, 1'b0, 16'h1111);
    vec[5] = mk(0, 15'h4321, 1'b0, 2'b10, 16'hFFFF, 1'b1, 1'b0, 16'h8001);
    for (int v = 0; v < 6; v++) begin
      issue(vec[v]);
      drive_now();
      run_until_idle("vec", 20);
      tick();
      chk("vec_idle_bsy", m_wb_bsy_o, 2'b11);
      chk("vec_idle_cyc", s_wb_cyc_o, 1'b0);
    end

`ifdef DCACHE_ARB_CYCLOCK_EN
    // Lock: three writes from requester 0 complete before requester 1's read.
    reset_pulse();
    issue(mk(0, 15'h0010, 1'b1, 2'b11, 16'h1000, 1'b0, 1'b0, 16'h0000));
    issue(mk(1, 15'h0020, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h2222));
    exp_q.delete();
    exp_q.push_back(mq[0][0]);
    mq[0].push_back(mk(0, 15'h0011, 1'b1, 2'b11, 16'h1001, 1'b0, 1'b0, 16'h0000));
    mq[0].push_back(mk(0, 15'h0012, 1'b1, 2'b11, 16'h1002, 1'b0, 1'b0, 16'h0000));
    exp_q.push_back(mq[0][1]);
    exp_q.push_back(mq[0][2]);
    exp_q.push_back(mq[1][0]);
    drive_now();
    run_until_idle("lock", 60);
`else
    // Fairness: both requesters continuously requesting alternate grants.
    reset_pulse();
    mq[0].push_back(mk(0, 15'h0A00, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hA000));
    mq[0].push_back(mk(0, 15'h0A01, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hA001));
    mq[1].push_back(mk(1, 15'h0B00, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hB000));
    mq[1].push_back(mk(1, 15'h0B01, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hB001));
    exp_q.push_back(mq[0][0]);
    exp_q.push_back(mq[1][0]);
    exp_q.push_back(mq[0][1]);
    exp_q.push_back(mq[1][1]);
    cyc_hold = 2'b11;
    drive_now();
    run_until_idle("fair", 60);
`endif
    tick();

    // Backpressure with cmiss sideband; a stray ack in ISSUE must be ignored.
    s_wb_bsy_i = 1'b1;
    issue(mk(1, 15'h0033, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h3333));
    drive_now();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_stb", s_wb_stb_o, 1'b1);
      chk("bp_cmiss", s_cmiss_o, 1'b1);
      chk("bp_bsy", m_wb_bsy_o, 2'b11);
      if (i == 2) begin
        s_wb_ack_i = 1'b1;
        #1;
        chk("bp_stray_ack", m_wb_ack_o, 2'b00);
      end
      tick();
    end
    s_wb_bsy_i = 1'b0;
    #1;
    chk("bp_release_bsy", m_wb_bsy_o, 2'b01);
    run_until_idle("bp", 20);
    tick();

    // Abandon: requester 0 drops cyc while the cache is still working.
    ack_lat = 3;
    issue(mk(0, 15'h0044, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h4444));
    drive_now();
    tick();
    tick();
    cyc_hold[0] = 1'b0;
    drive_now();
    n = 0;
    while (ack_q.size() > 0 && n < 20) begin
      chk("abandon_cyc", s_wb_cyc_o, 1'b1);
      chk("abandon_stb", s_wb_stb_o, 1'b0);
      tick();
      n++;
    end
    chk("abandon_timeout", ack_q.size(), 0);
    chk("abandon_idle_cyc", s_wb_cyc_o, 1'b0);
    chk("abandon_idle_bsy", m_wb_bsy_o, 2'b11);
    ack_q.delete();
    ack_lat = 0;

    // Async reset in the middle of WAIT; requester 0 wins afterwards.
    ack_lat = 5;
    issue(mk(0, 15'h0055, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h5555));
    drive_now();
    tick();
    tick();
    chk("arst_pre_cyc", s_wb_cyc_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("arst_cyc", s_wb_cyc_o, 1'b0);
    chk("arst_stb", s_wb_stb_o, 1'b0);
    chk("arst_bsy", m_wb_bsy_o, 2'b11);
    chk("arst_ack", m_wb_ack_o, 2'b00);
    reset_model();
    rst_i = 1'b1;
    #1;
    issue(mk(0, 15'h0066, 1'b1, 2'b01, 16'h6666, 1'b0, 1'b0, 16'h0000));
    issue(mk(1, 15'h0077, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h7777));
    drive_now();
    run_until_idle("arst_after", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
